// File: rtl/sram_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_controller                                               |
// | Purpose  : Turns one 32-bit load/store from the MEM stage into two       |
// |            16-bit half-accesses on an external SRAM, low half first,     |
// |            and holds the pipeline frozen (ready=0) while doing so.       |
// | Ports    : clk, rst (async, active-high)                                 |
// |            rd_en, wr_en, address[31:0], write_data[31:0] - request       |
// |            read_data[31:0], ready                          - response    |
// |            sram_addr[17:0], sram_we_n, sram_dq_out[15:0], sram_dq_oe,    |
// |            sram_dq_in[15:0]                                - SRAM bus    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sram_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  // A single-cycle hold still needs a 1-bit counter so the compare is legal.
  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic        op_write_q, op_write_d;
  logic [31:0] read_data_q, read_data_d;

  // Halfword-pair index in SRAM; the byte offset bits fall away in the shift.
  logic [16:0] word_in;
  assign word_in = 17'((address - 32'(BASE_ADDR)) >> 2);

  logic req;
  assign req = rd_en | wr_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    op_write_d  = op_write_q;
    read_data_d = read_data_q;
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_we_n   = 1'b1;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;

    case (state_q)
      IDLE: begin
        // Combinational so the pipeline freezes in the request cycle itself.
        ready = ~req;
        if (req) begin
          word_d     = word_in;
          wdata_d    = write_data;
          op_write_d = wr_en;   // write wins when both are asserted
          cnt_d      = '0;
          state_d    = LOW;
        end
      end

      LOW: begin
        sram_addr = {word_q, 1'b0};
        if (op_write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end
        if (cnt_q == CNT_LAST) begin
          if (!op_write_q) read_data_d[15:0] = sram_dq_in;
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (op_write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end
        if (cnt_q == CNT_LAST) begin
          if (!op_write_q) read_data_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // Request inputs are still the old, stable ones here; ignore them.
        ready   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      op_write_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      op_write_q  <= op_write_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_controller                                            |
// | Purpose  : Self-checking bench for sram_controller. Holds a word-level   |
// |            memory model and a halfword SRAM model, and checks bus        |
// |            sequencing, freeze timing and load results.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sram_controller;

  localparam int W    = 2;
  localparam int BASE = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT, WAIT_CYCLES = 2
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  // Second DUT, WAIT_CYCLES = 1
  logic        d1_rd = 1'b0, d1_wr = 1'b0;
  logic [31:0] d1_addr = '0, d1_wdata = '0;
  logic [31:0] d1_read_data;
  logic        d1_ready;
  logic [17:0] d1_sram_addr;
  logic        d1_we_n;
  logic [15:0] d1_dq_out;
  logic        d1_dq_oe;
  logic [15:0] d1_dq_in = 16'h5A5A;

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst), .rd_en(d1_rd), .wr_en(d1_wr), .address(d1_addr),
    .write_data(d1_wdata), .read_data(d1_read_data), .ready(d1_ready),
    .sram_addr(d1_sram_addr), .sram_we_n(d1_we_n), .sram_dq_out(d1_dq_out),
    .sram_dq_oe(d1_dq_oe), .sram_dq_in(d1_dq_in)
  );

  // Halfword SRAM: writes on clock while the strobe is low, reads async.
  logic [15:0] sram_mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we)          sram_mem[pre_addr] <= pre_data;
    else if (!sram_we_n) sram_mem[sram_addr[9:0]] <= sram_dq_out;
  end
  assign sram_dq_in = sram_mem[sram_addr[9:0]];

  // Reference: 32-bit word memory and the load result the DUT should hold.
  logic [31:0] ref_mem [0:511];
  logic [31:0] exp_rd = '0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access on the W=2 DUT. Starts at a falling edge (cycle 0 of the
  // request), ends at the falling edge of the DONE cycle. With hold=1 the
  // request stays asserted through DONE, as a frozen pipeline would leave it.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit hold);
    logic [16:0] word;
    bit          is_wr;
    bit          half;
    logic [15:0] exp_dq;
    word  = 17'((addr - 32'(BASE)) >> 2);
    is_wr = wr;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    #1 chk("ready_req_cycle", {31'd0, ready}, 32'd0);
    for (int k = 1; k <= 2*W + 1; k++) begin
      @(negedge clk);
      if (k <= 2*W) begin
        half   = (k > W);
        exp_dq = !is_wr ? 16'd0 : (half ? wdata[31:16] : wdata[15:0]);
        chk("sram_addr", {14'd0, sram_addr}, {14'd0, word, half});
        chk("we_n",      {31'd0, sram_we_n}, {31'd0, !is_wr});
        chk("dq_oe",     {31'd0, sram_dq_oe}, {31'd0, is_wr});
        chk("dq_out",    {16'd0, sram_dq_out}, {16'd0, exp_dq});
        chk("ready_busy", {31'd0, ready}, 32'd0);
      end else begin
        if (is_wr) ref_mem[word[8:0]] = wdata;
        else       exp_rd = ref_mem[word[8:0]];
        chk("ready_done", {31'd0, ready}, 32'd1);
        chk("addr_done",  {14'd0, sram_addr}, 32'd0);
        chk("we_n_done",  {31'd0, sram_we_n}, 32'd1);
        chk("read_data",  read_data, exp_rd);
      end
    end
    if (!hold) begin
      rd_en = 1'b0; wr_en = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a, d;
    bit          r, h;
    for (int i = 0; i < 512; i++) ref_mem[i] = $urandom;
    ref_mem[2] = 32'hABCD1234;   // halfword 4 = 0x1234, halfword 5 = 0xABCD

    // Preload the SRAM from the reference while reset is held.
    pre_we = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pre_addr = 10'(i);
      pre_data = i[0] ? ref_mem[i >> 1][31:16] : ref_mem[i >> 1][15:0];
      @(negedge clk);
    end
    pre_we = 1'b0;

    // Reset state
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n",  {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe",    {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_addr",  {14'd0, sram_addr}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_we_n",  {31'd0, sram_we_n}, 32'd1);
    chk("idle_oe",    {31'd0, sram_dq_oe}, 32'd0);
    chk("idle_rdata", read_data, 32'd0);

    // Directed load, store, then back-to-back store/load with request held
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);
    chk("load_abcd1234", read_data, 32'hABCD1234);
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
    chk("rdata_held_after_store", read_data, 32'hABCD1234);
    do_access(1'b0, 1'b1, 32'd1024 + 32'd28, 32'h0BADF00D, 1'b1);
    do_access(1'b1, 1'b0, 32'd1024 + 32'd28, 32'd0, 1'b0);
    chk("b2b_load", read_data, 32'h0BADF00D);
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);
    chk("load_stored", read_data, 32'hDEADBEEF);

    // Randomized traffic; low address bits are don't-care
    for (int n = 0; n < 40; n++) begin
      a = 32'(BASE) + ($urandom_range(0, 511) << 2) + $urandom_range(0, 3);
      d = $urandom;
      r = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      do_access(r, !r, a, d, h);
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);

    // Reset during the HIGH half of a write
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1024 + 32'd40; write_data = 32'h13579BDF;
    repeat (W + 1) @(negedge clk);
    chk("mid_we_n_before", {31'd0, sram_we_n}, 32'd0);
    chk("mid_addr_before", {14'd0, sram_addr}, 32'd21);
    rst = 1'b1;
    #1;
    chk("mid_we_n_rst",  {31'd0, sram_we_n}, 32'd1);
    chk("mid_oe_rst",    {31'd0, sram_dq_oe}, 32'd0);
    chk("mid_addr_rst",  {14'd0, sram_addr}, 32'd0);
    chk("mid_rdata_rst", read_data, 32'd0);
    wr_en = 1'b0;
    #1 chk("mid_ready_rst", {31'd0, ready}, 32'd1);
    ref_mem[10][15:0] = 16'h9BDF;   // only the low half reached the SRAM
    exp_rd = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    chk("post_rst_rdata", read_data, 32'd0);
    do_access(1'b1, 1'b0, 32'd1024 + 32'd40, 32'd0, 1'b0);

    // Simultaneous rd_en/wr_en on the W=1 DUT: a write, frozen 3 cycles
    @(negedge clk);
    d1_rd = 1'b1; d1_wr = 1'b1; d1_addr = 32'd1024 + 32'd12; d1_wdata = 32'hCAFEF00D;
    #1 chk("w1_ready_c0", {31'd0, d1_ready}, 32'd0);
    @(negedge clk);
    chk("w1_ready_c1", {31'd0, d1_ready}, 32'd0);
    chk("w1_we_n_c1",  {31'd0, d1_we_n}, 32'd0);
    chk("w1_addr_c1",  {14'd0, d1_sram_addr}, 32'd6);
    chk("w1_dq_c1",    {16'd0, d1_dq_out}, 32'h0000F00D);
    @(negedge clk);
    chk("w1_ready_c2", {31'd0, d1_ready}, 32'd0);
    chk("w1_we_n_c2",  {31'd0, d1_we_n}, 32'd0);
    chk("w1_addr_c2",  {14'd0, d1_sram_addr}, 32'd7);
    chk("w1_dq_c2",    {16'd0, d1_dq_out}, 32'h0000CAFE);
    @(negedge clk);
    chk("w1_ready_c3", {31'd0, d1_ready}, 32'd1);
    chk("w1_we_n_c3",  {31'd0, d1_we_n}, 32'd1);
    chk("w1_rdata",    d1_read_data, 32'd0);
    d1_rd = 1'b0; d1_wr = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
